// File: rtl/dpram_pkg.sv
// Shared definitions for the parameterised dual-port RAM.
//   dpram_state_t      : clear-controller state encoding
//   COLLIDE_READ_OLD   : same-address read/write returns the pre-write word
//   COLLIDE_WRITE_THRU : same-address read/write returns the post-write word
package dpram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dpram_state_t;

    localparam int COLLIDE_READ_OLD   = 0;
    localparam int COLLIDE_WRITE_THRU = 1;

endpackage

// File: rtl/dpram_init_ctrl.sv
// Array clear sequencer. Walks a pointer over every word of the RAM and
// strobes a zero write at each address, one word per cycle.
//   clk, rst  : clock, synchronous active-high reset (restarts the clear)
//   clr       : request a clear while idle; ignored while clearing
//   busy      : clear in progress
//   clr_addr  : address being zeroed this cycle
//   clr_we    : zero-write strobe for clr_addr
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | array usable, waiting for clr
// ST_CLEAR | zeroing word at ptr, one word per cycle
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    dpram_state_t      state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                // Last word is written this cycle when the pointer is all ones.
                if (&ptr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/dpram_param.sv
// Parameterised simple dual-port RAM: one write port with byte enables,
// one read port with 1 or 2 cycles of registered latency, and a
// self-sequenced clear of the whole array after reset or on request.
//   clk, rst      : clock, synchronous active-high reset
//   clr           : one-cycle request to zero the array
//   we/waddr/wdata/wbe : write port, wbe[i] gates byte i
//   re/raddr      : read port, accepted every cycle
//   rdata/rvalid  : registered read data and its one-cycle qualifier
//   busy          : clear in progress, accesses ignored
module dpram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int RD_LAT       = 1,
    parameter int COLLIDE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic              busy_i;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;

    dpram_init_ctrl #(.ADDR_W(ADDR_W)) u_init_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy_i),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign busy = busy_i;

    logic [DATA_W-1:0] mem [DEPTH];

    // A clr in the idle cycle starts the clear, so that cycle's accesses are dropped too.
    logic acc, wr_en, rd_en;
    assign acc   = ~rst & ~busy_i & ~clr;
    assign wr_en = acc & we;
    assign rd_en = acc & re;

    logic [DATA_W-1:0] rd_word;

    always_comb begin
        rd_word = mem[raddr];
        if (COLLIDE_MODE == COLLIDE_WRITE_THRU && wr_en && (waddr == raddr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_word[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] s2_data;
            logic              s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rdata  = s2_data;
            assign rvalid = s2_valid;
        end else begin : g_lat1
            assign rdata  = s1_data;
            assign rvalid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_dpram_param.sv
module tb_dpram_param;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    wbe   = '0;
    logic          re    = 1'b0;
    logic [AW-1:0] raddr = '0;

    logic [DW-1:0] rdata0, rdata1, rdata2;
    logic          rvalid0, rvalid1, rvalid2;
    logic          busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // read-old, latency 1
    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COLLIDE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));
    // write-through, latency 1
    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .COLLIDE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));
    // read-old, latency 2
    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .COLLIDE_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2));

    // Reference model: word array, remaining-clear-cycle count, and the
    // expected visible outputs of each configuration.
    logic [DW-1:0] m_mem [DEPTH];
    int            busy_left = 0;
    logic          m_v1 = 1'b0, m_v2 = 1'b0;
    logic [DW-1:0] m_d1o = '0, m_d1w = '0, m_d2 = '0;

    task automatic idle_inputs();
        clr = 1'b0; we = 1'b0; re = 1'b0; rst = 1'b0; wbe = '0;
    endtask

    // One clock: apply the spec rules to the model using the inputs present at the edge.
    task automatic step();
        logic [DW-1:0] w;
        logic          nv2;
        logic [DW-1:0] nd2;
        bit            acc;
        @(posedge clk);
        if (rst) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_v1 = 1'b0; m_d1o = '0; m_d1w = '0; m_v2 = 1'b0; m_d2 = '0;
        end else begin
            nv2 = m_v1;
            nd2 = m_v1 ? m_d1o : m_d2;
            acc = (busy_left == 0) && !clr;
            if (busy_left > 0) begin
                busy_left--;
            end else if (clr) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
            m_v1 = 1'b0;
            if (acc && re) begin
                m_v1  = 1'b1;
                m_d1o = m_mem[raddr];
                w     = m_mem[raddr];
                if (we && waddr == raddr) begin
                    for (int b = 0; b < 2; b++) if (wbe[b]) w[8*b +: 8] = wdata[8*b +: 8];
                end
                m_d1w = w;
            end
            if (acc && we) begin
                for (int b = 0; b < 2; b++) if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
            end
            m_v2 = nv2;
            m_d2 = nd2;
        end
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        step();
        n_checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b%b%b expected 111", busy0, busy1, busy2);
        end
        n_checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_rvalid: got %b%b%b expected 000", rvalid0, rvalid1, rvalid2);
        end
        n_checks++;
        if (rdata0 !== 16'h0 || rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h %h %h expected 0000", rdata0, rdata1, rdata2);
        end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy0) break;
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++; $display("FAIL reset_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) begin
            re = 1'b1; raddr = AW'(a);
            step();
            n_checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== 16'h0000) begin
                n_fail++; $display("FAIL reset_readback[%0d]: got v=%b d=%h expected v=1 d=0000", a, rvalid0, rdata0);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_byte_enable();
        we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; wbe = 2'b11;
        step();
        wdata = 16'h1234; wbe = 2'b01;
        step();
        idle_inputs();
        re = 1'b1; raddr = 4'd3;
        step();
        idle_inputs();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 16'hBE34) begin
            n_fail++; $display("FAIL byte_en_lat1: got v=%b d=%h expected v=1 d=be34", rvalid0, rdata0);
        end
        n_checks++;
        if (rvalid2 !== 1'b0) begin
            n_fail++; $display("FAIL byte_en_lat2_early: got v=%b expected v=0", rvalid2);
        end
        step();
        n_checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 16'hBE34) begin
            n_fail++; $display("FAIL byte_en_hold: got v=%b d=%h expected v=0 d=be34", rvalid0, rdata0);
        end
        n_checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 16'hBE34) begin
            n_fail++; $display("FAIL byte_en_lat2: got v=%b d=%h expected v=1 d=be34", rvalid2, rdata2);
        end
    endtask

    task automatic test_collision();
        we = 1'b1; waddr = 4'd5; wdata = 16'h1111; wbe = 2'b11;
        step();
        wdata = 16'h2222; re = 1'b1; raddr = 4'd5;
        step();
        n_checks++;
        if (rdata0 !== 16'h1111 || rdata1 !== 16'h2222) begin
            n_fail++; $display("FAIL collide_full: got old=%h thru=%h expected old=1111 thru=2222", rdata0, rdata1);
        end
        wdata = 16'hABCD; wbe = 2'b01;
        step();
        idle_inputs();
        n_checks++;
        if (rdata0 !== 16'h2222 || rdata1 !== 16'h22CD) begin
            n_fail++; $display("FAIL collide_partial: got old=%h thru=%h expected old=2222 thru=22cd", rdata0, rdata1);
        end
        step();
        n_checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 16'h2222) begin
            n_fail++; $display("FAIL collide_lat2: got v=%b d=%h expected v=1 d=2222", rvalid2, rdata2);
        end
    endtask

    task automatic test_clr();
        int cnt;
        bit stray;
        re = 1'b1; raddr = 4'd3;
        step();
        clr = 1'b1; we = 1'b1; waddr = 4'd7; wdata = 16'hFFFF; wbe = 2'b11;
        step();
        idle_inputs();
        n_checks++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0) begin
            n_fail++; $display("FAIL clr_start: got busy=%b v=%b expected busy=1 v=0", busy0, rvalid0);
        end
        n_checks++;
        if (rvalid2 !== 1'b1 || rdata2 !== 16'hBE34) begin
            n_fail++; $display("FAIL clr_inflight: got v=%b d=%h expected v=1 d=be34", rvalid2, rdata2);
        end
        cnt = 0; stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy0) break;
            cnt++;
            clr = (cnt == 5);
            re = 1'b1; raddr = 4'($urandom_range(15));
            step();
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) stray = 1'b1;
        end
        idle_inputs();
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++; $display("FAIL clr_busy_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
        n_checks++;
        if (stray) begin
            n_fail++; $display("FAIL clr_read_while_busy: got rvalid=1 expected rvalid=0");
        end
        re = 1'b1; raddr = 4'd7;
        step();
        idle_inputs();
        n_checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 16'h0000) begin
            n_fail++; $display("FAIL clr_dropped_write: got v=%b d=%h expected v=1 d=0000", rvalid0, rdata0);
        end
    endtask

    task automatic test_rst_mid_clear();
        int cnt;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy0) break;
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != DEPTH) begin
            n_fail++; $display("FAIL rst_mid_clear_len: got %0d cycles expected %0d", cnt, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wd [3];
        logic          ev;
        logic [DW-1:0] ed;
        for (int a = 0; a < 3; a++) begin
            wd[a] = DW'($urandom);
            we = 1'b1; waddr = AW'(a); wdata = wd[a]; wbe = 2'b11;
            step();
        end
        idle_inputs();
        ed = rdata2;
        for (int k = 0; k < 6; k++) begin
            re = (k < 3); raddr = AW'(k);
            step();
            ev = (k >= 1 && k <= 3);
            if (ev) ed = wd[k-1];
            n_checks++;
            if (rvalid2 !== ev || (ev && rdata2 !== ed)) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got v=%b d=%h expected v=%b d=%h", k, rvalid2, rdata2, ev, ed);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 500; c++) begin
            rst   = ($urandom_range(199) == 0);
            clr   = ($urandom_range(63) == 0);
            we    = $urandom_range(1);
            re    = $urandom_range(1);
            waddr = AW'($urandom_range(15));
            raddr = ($urandom_range(3) == 0) ? waddr : AW'($urandom_range(15));
            wdata = DW'($urandom);
            wbe   = 2'($urandom_range(3));
            step();
            n_checks++;
            if (busy0 !== (busy_left > 0) || busy2 !== (busy_left > 0)) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy0, busy_left > 0);
            end
            n_checks++;
            if (rvalid0 !== m_v1 || rdata0 !== m_d1o) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_old[%0d]: got v=%b d=%h expected v=%b d=%h", c, rvalid0, rdata0, m_v1, m_d1o);
            end
            n_checks++;
            if (rvalid1 !== m_v1 || rdata1 !== m_d1w) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_thru[%0d]: got v=%b d=%h expected v=%b d=%h", c, rvalid1, rdata1, m_v1, m_d1w);
            end
            n_checks++;
            if (rvalid2 !== m_v2 || rdata2 !== m_d2) begin
                n_fail++; errs++;
                if (errs < 10) $display("FAIL rand_lat2[%0d]: got v=%b d=%h expected v=%b d=%h", c, rvalid2, rdata2, m_v2, m_d2);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        test_reset();
        test_byte_enable();
        test_collision();
        test_clr();
        test_rst_mid_clear();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_param.md
DPRAM_PARAM -- requirements
Module: dpram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter COLLIDE_MODE, default 0: 0 = read-old, 1 = write-through on same-address read/write.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port clr  input  1  one-cycle request to zero the whole array.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port waddr  input  ADDR_W  write address.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port wbe  input  DATA_W/8  byte enables; bit i gates wdata[8i+7:8i].
REQ-012 SHALL have port re  input  1  read enable.
REQ-013 SHALL have port raddr  input  ADDR_W  read address.
REQ-014 SHALL have port rdata  output  DATA_W  registered read data.
REQ-015 SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-016 SHALL have port busy  output  1  array clear in progress; accesses ignored.

Function
REQ-017 SHALL implement FSM states IDLE and CLEAR; rst forces CLEAR with clear pointer 0.
REQ-018 In CLEAR, SHALL write zero to address pointer each cycle, increment pointer, enter IDLE after writing DEPTH-1 (exactly DEPTH cycles).
REQ-019 busy SHALL be 1 exactly while state is CLEAR.
REQ-020 In IDLE, clr=1 SHALL enter CLEAR next cycle with pointer 0; any we/re in that same cycle is ignored.
REQ-021 clr during CLEAR SHALL be ignored (no restart); rst during CLEAR SHALL restart from pointer 0.
REQ-022 we and re while busy=1 SHALL have no effect on the array, rdata or rvalid.
REQ-023 In IDLE, we=1 SHALL update only bytes of mem[waddr] whose wbe bit is 1, same edge; wbe=0 is a no-op.
REQ-024 In IDLE, re=1 SHALL produce mem[raddr] on rdata with rvalid=1 exactly RD_LAT cycles later.
REQ-025 Reads SHALL be accepted every cycle (full throughput); RD_LAT=2 adds one output register stage.
REQ-026 rdata SHALL hold last read value when no read completes; never driven to X or Z.
REQ-027 Same-cycle we and re, waddr==raddr: COLLIDE_MODE 0 SHALL return pre-write word; mode 1 SHALL return post-write word (enabled bytes new, others old).
REQ-028 Same-cycle we and re, different addresses: both SHALL complete independently.
REQ-029 Reads in flight when CLEAR starts via clr SHALL still complete with their captured data.

Reset
REQ-030 While rst=1: rdata=0, rvalid=0, read pipeline flushed, state CLEAR, pointer 0, busy=1.
REQ-031 After rst deasserts, busy SHALL stay 1 for DEPTH cycles; every word SHALL read 0 afterward.

Structure
REQ-032 Package dpram_pkg SHALL hold the FSM state enum and COLLIDE_READ_OLD=0 / COLLIDE_WRITE_THRU=1 constants.
REQ-033 Clear FSM and pointer SHALL live in sub-module dpram_init_ctrl (outputs busy, clear address, clear write strobe).
REQ-034 Array SHALL be a single reg array inferable as block RAM; no per-word reset in the array.

Verification (DATA_W=16, ADDR_W=4, RD_LAT=1 unless noted)
REQ-035 rst 1 cycle, then monitor -> busy=1 for exactly 16 cycles; reads of addresses 0..15 return 0x0000.
REQ-036 write 0xBEEF to addr 3 wbe=11, then wbe=01 data 0x1234 -> read addr 3 gives 0xBE34, rvalid one cycle after re.
REQ-037 addr 5 holds 0x1111; same cycle we addr 5 data 0x2222 wbe=11 and re addr 5 -> mode 0 rdata 0x1111, mode 1 rdata 0x2222.
REQ-038 clr in IDLE with we addr 7 same cycle -> write dropped, busy 16 cycles, addr 7 reads 0x0000; re during busy -> no rvalid.
REQ-039 rst asserted at clear pointer 9 -> clear restarts at 0, busy 16 cycles after rst release.
REQ-040 RD_LAT=2, back-to-back re on addresses 0,1,2 -> three consecutive rvalid pulses two cycles later, data in order.
